// File: rtl/mem_fifo_ctrl_pkg.sv
// rtl/mem_fifo_ctrl_pkg.sv - shared state encodings and width defaults for mem_fifo_ctrl
// Purpose: FSM state type and default widths for the storage-array FIFO controller.
// Ports: none (package).
package mem_fifo_ctrl_pkg;

   localparam int DW_DEF = 2;   // array word width
   localparam int AW_DEF = 3;   // array address width (8 words)

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_W_SETUP  = 2'd1,
      ST_W_STROBE = 2'd2,
      ST_R_FETCH  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_fifo_ptr.sv
// rtl/mem_fifo_ptr.sv - AW-bit wrapping pointer with increment enable
// Purpose: address pointer into the storage array; wraps modulo 2**AW.
// Ports:
//   clk   in   1    rising-edge clock
//   rst_n in   1    synchronous active-low reset, clears the pointer
//   inc   in   1    advance pointer by one on this edge
//   ptr   out  AW   current pointer value
module mem_fifo_ptr #(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (inc) begin
         // Natural overflow of the AW-bit add gives the 7->0 wrap.
         ptr <= ptr + {{(AW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - valid/ready FIFO controller driving an edge-written storage array
// Purpose: sequences pushes into address/data/write-strobe cycles on an external
//   array and prefetches the oldest word into a one-entry output register.
// Ports:
//   CLK       in   1     clock, rising edge
//   RST_N     in   1     synchronous active-low reset
//   IN_VALID  in   1     push request
//   IN_DATA   in   DW    push word
//   IN_READY  out  1     push accepted on IN_VALID && IN_READY
//   OUT_VALID out  1     OUT_DATA holds the oldest word
//   OUT_DATA  out  DW    head word (registered)
//   OUT_READY in   1     pop on OUT_VALID && OUT_READY
//   MEM_AD    out  AW    shared array address (write and read)
//   MEM_D     out  DW    array write data
//   MEM_WR    out  1     array write strobe (array latches on its rising edge)
//   MEM_Q     in   DW    array async read data at MEM_AD
//   COUNT     out  AW+1  words resident in the array, excluding OUT_DATA
//   FULL      out  1     COUNT == DEPTH
//   EMPTY     out  1     COUNT == 0 and no word in the output register
module mem_fifo_ctrl
   import mem_fifo_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_VALID,
   input  logic [DW-1:0] IN_DATA,
   output logic          IN_READY,
   output logic          OUT_VALID,
   output logic [DW-1:0] OUT_DATA,
   input  logic          OUT_READY,
   output logic [AW-1:0] MEM_AD,
   output logic [DW-1:0] MEM_D,
   output logic          MEM_WR,
   input  logic [DW-1:0] MEM_Q,
   output logic [AW:0]   COUNT,
   output logic          FULL,
   output logic          EMPTY
);

   localparam int          DEPTH      = 1 << AW;
   localparam logic [AW:0] COUNT_FULL = DEPTH[AW:0];
   localparam logic [AW:0] COUNT_ONE  = {{AW{1'b0}}, 1'b1};

   state_t          state;
   state_t          state_next;
   logic [DW-1:0]   hold;
   logic [AW:0]     count;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            mem_wr;
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            fetch_req;
   logic            in_ready;
   logic            push_acc;

   // Refill the output register whenever it is empty and the array has data.
   assign fetch_req = !out_valid && (count != '0);
   assign in_ready  = (state == ST_IDLE) && !fetch_req && (count != COUNT_FULL);
   assign push_acc  = IN_VALID && in_ready;

   mem_fifo_ptr #(.AW(AW)) u_wptr (
      .clk   (CLK),
      .rst_n (RST_N),
      .inc   (state == ST_W_STROBE),
      .ptr   (wptr)
   );

   mem_fifo_ptr #(.AW(AW)) u_rptr (
      .clk   (CLK),
      .rst_n (RST_N),
      .inc   (state == ST_R_FETCH),
      .ptr   (rptr)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (fetch_req) begin
               state_next = ST_R_FETCH;
            end else if (push_acc) begin
               state_next = ST_W_SETUP;
            end
         end
         ST_W_SETUP:  state_next = ST_W_STROBE;
         ST_W_STROBE: state_next = ST_IDLE;
         ST_R_FETCH:  state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         hold      <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         mem_wr    <= 1'b0;
      end else begin
         state  <= state_next;
         // Registered strobe: high for exactly the cycle spent in W_STROBE,
         // so AD/D set up during W_SETUP are stable a full cycle before it rises.
         mem_wr <= (state_next == ST_W_STROBE);

         if (push_acc) begin
            hold <= IN_DATA;
         end

         if (state == ST_W_STROBE) begin
            count <= count + COUNT_ONE;
         end else if (state == ST_R_FETCH) begin
            count <= count - COUNT_ONE;
         end

         // A capture and a pop cannot coincide: fetch only runs with out_valid low.
         if (state == ST_R_FETCH) begin
            out_data  <= MEM_Q;
            out_valid <= 1'b1;
         end else if (out_valid && OUT_READY) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid;
   assign OUT_DATA  = out_data;
   assign MEM_AD    = (state == ST_R_FETCH) ? rptr : wptr;
   assign MEM_D     = hold;
   assign MEM_WR    = mem_wr;
   assign COUNT     = count;
   assign FULL      = (count == COUNT_FULL);
   assign EMPTY     = (count == '0) && !out_valid;

endmodule
